// File: rtl/mcu_pkg.sv
// Shared constants for the microprogrammed MIPS control unit: microstate numbering,
// sequencing-field encodings and the next-microstate selection used by the sequencer.
package mcu_pkg;

    localparam int UPC_W = 5;
    localparam logic [UPC_W-1:0] FETCH_STATE = UPC_W'(0);
    localparam logic [UPC_W-1:0] EXC_STATE   = UPC_W'(31);

    localparam logic [1:0] SEQ_FETCH = 2'b00;
    localparam logic [1:0] SEQ_DISP1 = 2'b01;
    localparam logic [1:0] SEQ_DISP2 = 2'b10;
    localparam logic [1:0] SEQ_INCR  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MDU = 2'd1,
        ST_EXC      = 2'd2
    } fsm_t;

    // Increment wraps in UPC_W bits, so the last ordinary microstate steps into EXC_STATE.
    function automatic logic [UPC_W-1:0] seq_target(
        input logic [1:0]       seq,
        input logic [UPC_W-1:0] cur,
        input logic [UPC_W-1:0] d1,
        input logic [UPC_W-1:0] d2
    );
        logic [UPC_W-1:0] t;
        t = FETCH_STATE;
        case (seq)
            SEQ_FETCH: t = FETCH_STATE;
            SEQ_DISP1: t = d1;
            SEQ_DISP2: t = d2;
            SEQ_INCR:  t = cur + UPC_W'(1);
            default:   t = FETCH_STATE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mdu_stall_timer.sv
// Counts cycles spent waiting on the MDU; tc flags the last allowed wait cycle.
module mdu_stall_timer #(
    parameter int MAX_STALL = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;

    logic [CW-1:0] count_reg;

    assign tc = (count_reg == CW'(MAX_STALL - 1));

    // Saturates at the terminal count; the sequencer leaves WAIT_MDU on that cycle anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !tc) begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: picks the next microstate, stalls on multi-cycle MDU ops and
// converts undefined-instruction dispatches and MDU hangs into exception pulses.
module micro_sequencer
    import mcu_pkg::*;
#(
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       seq_ctrl,
    input  logic [UPC_W-1:0] dt1_next,
    input  logic [UPC_W-1:0] dt2_next,
    input  logic             mdu_wait,
    input  logic             mdu_done,
    output logic [UPC_W-1:0] upc,
    output logic             stall,
    output logic             exc_undef,
    output logic             exc_timeout,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    fsm_t             state_reg, state_next;
    logic [UPC_W-1:0] upc_reg, upc_next;
    logic [1:0]       seq_hold_reg, seq_hold_next;
    logic             stall_reg, stall_next;
    logic             exc_undef_reg, exc_undef_next;
    logic             exc_timeout_reg, exc_timeout_next;
    logic             retire_reg, retire_next;
    logic [CNT_W-1:0] retire_cnt_reg, retire_cnt_next;

    logic             timer_clear, timer_en, timer_tc;
    logic             resolve;
    logic [1:0]       resolve_seq;
    logic [UPC_W-1:0] target;

    mdu_stall_timer #(
        .MAX_STALL (MAX_STALL)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .tc      (timer_tc)
    );

    // While stalled the held sequencing field is used, but dispatch inputs stay live.
    assign resolve_seq = (state_reg == ST_WAIT_MDU) ? seq_hold_reg : seq_ctrl;
    assign target      = seq_target(resolve_seq, upc_reg, dt1_next, dt2_next);

    always_comb begin
        state_next       = state_reg;
        upc_next         = upc_reg;
        seq_hold_next    = seq_hold_reg;
        exc_undef_next   = 1'b0;
        exc_timeout_next = 1'b0;
        retire_next      = 1'b0;
        retire_cnt_next  = retire_cnt_reg;
        timer_clear      = 1'b0;
        timer_en         = 1'b0;
        resolve          = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (mdu_wait) begin
                    seq_hold_next = seq_ctrl;
                    state_next    = ST_WAIT_MDU;
                    timer_clear   = 1'b1;
                end else begin
                    resolve = 1'b1;
                end
            end
            ST_WAIT_MDU: begin
                timer_en = 1'b1;
                if (mdu_done) begin
                    resolve = 1'b1;
                end else if (timer_tc) begin
                    exc_timeout_next = 1'b1;
                    upc_next         = EXC_STATE;
                    state_next       = ST_EXC;
                end
            end
            ST_EXC: begin
                upc_next   = FETCH_STATE;
                state_next = ST_RUN;
            end
            default: begin
                upc_next   = FETCH_STATE;
                state_next = ST_RUN;
            end
        endcase

        if (resolve) begin
            if (target == EXC_STATE) begin
                upc_next       = EXC_STATE;
                state_next     = ST_EXC;
                exc_undef_next = 1'b1;
            end else begin
                upc_next   = target;
                state_next = ST_RUN;
                // A held fetch (already in FETCH_STATE) is not a completed instruction.
                if (target == FETCH_STATE && upc_reg != FETCH_STATE) begin
                    retire_next     = 1'b1;
                    retire_cnt_next = retire_cnt_reg + CNT_W'(1);
                end
            end
        end

        stall_next = (state_next == ST_WAIT_MDU);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_RUN;
            upc_reg         <= FETCH_STATE;
            seq_hold_reg    <= SEQ_FETCH;
            stall_reg       <= 1'b0;
            exc_undef_reg   <= 1'b0;
            exc_timeout_reg <= 1'b0;
            retire_reg      <= 1'b0;
            retire_cnt_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            upc_reg         <= upc_next;
            seq_hold_reg    <= seq_hold_next;
            stall_reg       <= stall_next;
            exc_undef_reg   <= exc_undef_next;
            exc_timeout_reg <= exc_timeout_next;
            retire_reg      <= retire_next;
            retire_cnt_reg  <= retire_cnt_next;
        end
    end

    assign upc         = upc_reg;
    assign stall       = stall_reg;
    assign exc_undef   = exc_undef_reg;
    assign exc_timeout = exc_timeout_reg;
    assign retire      = retire_reg;
    assign retire_cnt  = retire_cnt_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a cycle-level reference model of the sequencing
// rules is compared every cycle, plus hand-computed expectations at key points.
module tb_micro_sequencer;

    localparam int MAX_STALL = 64;
    localparam int CNT_W     = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [1:0]       seq_ctrl = 2'b00;
    logic [4:0]       dt1_next = 5'd0;
    logic [4:0]       dt2_next = 5'd0;
    logic             mdu_wait = 1'b0;
    logic             mdu_done = 1'b0;
    logic [4:0]       upc;
    logic             stall;
    logic             exc_undef;
    logic             exc_timeout;
    logic             retire;
    logic [CNT_W-1:0] retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    micro_sequencer #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seq_ctrl    (seq_ctrl),
        .dt1_next    (dt1_next),
        .dt2_next    (dt2_next),
        .mdu_wait    (mdu_wait),
        .mdu_done    (mdu_done),
        .upc         (upc),
        .stall       (stall),
        .exc_undef   (exc_undef),
        .exc_timeout (exc_timeout),
        .retire      (retire),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an instruction either waits (counting its stall cycles), takes an
    // exception for one cycle, or moves to the microstate named by its sequencing field.
    int          m_upc = 0;
    bit          m_stall = 0, m_undef = 0, m_tmo = 0, m_ret = 0, m_in_exc = 0;
    int          m_waited = 0;
    int          m_hold = 0;
    logic [31:0] m_cnt = 0;

    function automatic int pick(int s, int cur, int d1, int d2);
        if (s == 0) return 0;
        if (s == 1) return d1;
        if (s == 2) return d2;
        return (cur + 1) % 32;
    endfunction

    task automatic model_go(input int s);
        int t;
        t = pick(s, m_upc, int'(dt1_next), int'(dt2_next));
        m_stall = 0;
        if (t == 31) begin
            m_undef  = 1;
            m_in_exc = 1;
            m_upc    = 31;
        end else begin
            if (t == 0 && m_upc != 0) begin
                m_ret = 1;
                m_cnt = m_cnt + 1;
            end
            m_upc = t;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_upc = 0; m_stall = 0; m_undef = 0; m_tmo = 0; m_ret = 0;
            m_in_exc = 0; m_waited = 0; m_hold = 0; m_cnt = 0;
        end else begin
            m_undef = 0; m_tmo = 0; m_ret = 0;
            if (m_in_exc) begin
                m_in_exc = 0;
                m_upc    = 0;
            end else if (m_stall) begin
                m_waited++;
                if (mdu_done) begin
                    model_go(m_hold);
                end else if (m_waited == MAX_STALL) begin
                    m_tmo    = 1;
                    m_stall  = 0;
                    m_in_exc = 1;
                    m_upc    = 31;
                end
            end else if (mdu_wait) begin
                m_hold   = int'(seq_ctrl);
                m_stall  = 1;
                m_waited = 0;
            end else begin
                model_go(int'(seq_ctrl));
            end
        end
    end

    always @(negedge clk) begin
        chk("upc", longint'(upc), longint'(m_upc));
        chk("stall", longint'(stall), longint'(m_stall));
        chk("exc_undef", longint'(exc_undef), longint'(m_undef));
        chk("exc_timeout", longint'(exc_timeout), longint'(m_tmo));
        chk("retire", longint'(retire), longint'(m_ret));
        chk("retire_cnt", longint'(retire_cnt), longint'(m_cnt));
    end

    // Drive one microword at a falling edge and return at the next falling edge.
    task automatic cyc(input logic [1:0] s, input logic [4:0] d1, input logic [4:0] d2,
                       input logic w, input logic dn);
        seq_ctrl = s; dt1_next = d1; dt2_next = d2; mdu_wait = w; mdu_done = dn;
        @(negedge clk);
        $display("[TB] seq=%0d dt1=%0d dt2=%0d wait=%0d done=%0d -> upc=%0d stall=%0d undef=%0d tmo=%0d retire=%0d cnt=%0d",
                 s, d1, d2, w, dn, upc, stall, exc_undef, exc_timeout, retire, retire_cnt);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_upc", longint'(upc), 0);
        chk("reset_stall", longint'(stall), 0);
        chk("reset_cnt", longint'(retire_cnt), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // add flow
        cyc(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("incr_upc", longint'(upc), 1);
        cyc(2'b01, 5'd12, 5'd0, 1'b0, 1'b0);
        chk("disp1_upc", longint'(upc), 12);
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("add_retire", longint'(retire), 1);
        chk("add_cnt", longint'(retire_cnt), 1);
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("held_fetch_retire", longint'(retire), 0);

        // memory-op split via table 2, then increment
        cyc(2'b01, 5'd3, 5'd0, 1'b0, 1'b0);
        cyc(2'b10, 5'd0, 5'd20, 1'b0, 1'b0);
        chk("disp2_upc", longint'(upc), 20);
        cyc(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("incr21_upc", longint'(upc), 21);
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);

        // undefined instruction
        cyc(2'b01, 5'd31, 5'd0, 1'b0, 1'b0);
        chk("undef_upc", longint'(upc), 31);
        chk("undef_pulse", longint'(exc_undef), 1);
        cyc(2'b11, 5'd7, 5'd7, 1'b1, 1'b1);
        chk("exc_exit_upc", longint'(upc), 0);
        chk("exc_exit_retire", longint'(retire), 0);

        // mult stall, done after 10 wait cycles
        cyc(2'b01, 5'd16, 5'd0, 1'b0, 1'b0);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("mult_stall", longint'(stall), 1);
        chk("mult_hold_upc", longint'(upc), 16);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("mult_upc", longint'(upc), 0);
        chk("mult_retire", longint'(retire), 1);
        chk("mult_cnt", longint'(retire_cnt), 3);

        // held disp1 resolves against the live dispatch value at mdu_done
        cyc(2'b01, 5'd5, 5'd0, 1'b0, 1'b0);
        cyc(2'b01, 5'd2, 5'd0, 1'b1, 1'b0);
        cyc(2'b00, 5'd4, 5'd0, 1'b0, 1'b0);
        cyc(2'b00, 5'd9, 5'd0, 1'b0, 1'b1);
        chk("held_disp1_upc", longint'(upc), 9);
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);

        // timeout after the 64th wait cycle
        cyc(2'b01, 5'd16, 5'd0, 1'b0, 1'b0);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MAX_STALL - 1; i++) cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("tmo_not_yet", longint'(exc_timeout), 0);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        chk("tmo_pulse", longint'(exc_timeout), 1);
        chk("tmo_upc", longint'(upc), 31);
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("tmo_exit_upc", longint'(upc), 0);
        chk("tmo_cnt", longint'(retire_cnt), 4);

        // done on the 64th wait cycle beats the timeout
        cyc(2'b01, 5'd16, 5'd0, 1'b0, 1'b0);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < MAX_STALL - 1; i++) cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b1);
        chk("late_done_tmo", longint'(exc_timeout), 0);
        chk("late_done_retire", longint'(retire), 1);
        chk("late_done_cnt", longint'(retire_cnt), 5);

        // increment boundary into the exception microstate
        cyc(2'b01, 5'd30, 5'd0, 1'b0, 1'b0);
        cyc(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("incr31_upc", longint'(upc), 31);
        chk("incr31_undef", longint'(exc_undef), 1);
        cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);

        // asynchronous reset in the middle of a stall
        cyc(2'b01, 5'd16, 5'd0, 1'b0, 1'b0);
        cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(2'b00, 5'd0, 5'd0, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_upc", longint'(upc), 0);
        chk("async_stall", longint'(stall), 0);
        chk("async_cnt", longint'(retire_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < MAX_STALL + 4; i++) cyc(2'b00, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("post_reset_cnt", longint'(retire_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
